imem_prog_loader: RTL
=====================

# imem_prog_loader

Program loader that writes a byte stream into the byte-wide instruction memory and holds the fetch stage until the image is complete. Sits between an external byte source (testbench or host link) and the instruction-memory write port, and drives the fetch stage's `stall`/`branch_en`/`branch_pc` inputs. After the last byte it redirects fetch to `START_PC` and releases the core.

## Interface
Parameters:
- `ADDR_W`, 16, instruction-memory byte-address width (65536 bytes)
- `BASE_ADDR`, 0, first byte address written
- `START_PC`, 64'h0, PC issued to fetch on release

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  source byte valid
- `in_byte`  in  8  source byte; consecutive bytes fill ascending addresses (little-endian within each word)
- `in_last`  in  1  qualifies final byte of image
- `in_ready`  out  1  loader accepts a byte this cycle
- `mem_we`  out  1  byte write strobe
- `mem_addr`  out  ADDR_W  byte write address
- `mem_wdata`  out  8  byte write data
- `core_stall`  out  1  to fetch `stall`
- `core_branch_en`  out  1  to fetch `branch_en`
- `core_branch_pc`  out  64  to fetch `branch_pc`
- `load_done`  out  1  image loaded, core running
- `byte_count`  out  ADDR_W+1  bytes written so far, including pad
- `err_overflow`  out  1  sticky, image exceeded memory
- `err_checksum`  out  1  sticky, checksum mismatch (0 when feature compiled out)

## Operation
- Accept on `in_valid && in_ready`. States: LOAD, PAD, RELEASE, RUN, ERROR.
- LOAD (reset state): `in_ready`=1. Each accepted byte is written at `BASE_ADDR + byte_count`, then `byte_count` increments. Accepted with `in_last`: go to PAD if new `byte_count[1:0]`≠0, else RELEASE.
- PAD: `in_ready`=0. Write 8'h00 at successive addresses until `byte_count[1:0]`==0, then RELEASE.
- RELEASE: one cycle. `core_branch_en`=1, `core_branch_pc`=`START_PC`. Next state is RUN.
- RUN: `core_stall`=0, `load_done`=1, `in_ready`=0. Terminal until `rst`.
- ERROR: `in_ready`=0, `core_stall`=1, no writes. Terminal until `rst`.
- Overflow: accepted byte when `BASE_ADDR + byte_count` == 2^ADDR_W: byte not written, `err_overflow`=1, go to ERROR. Same rule for a pad write.
- `in_valid` while `in_ready`=0: ignored, not buffered.
- `core_stall`=1 in LOAD, PAD, RELEASE, ERROR. `branch_en` priority in fetch makes RELEASE redirect regardless of stall.
- `core_branch_pc` holds `START_PC` at all times. `core_branch_en` is 0 outside RELEASE.

## Timing
- Reset values: state LOAD, `in_ready`=1, `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0, `core_stall`=1, `core_branch_en`=0, `load_done`=0, `byte_count`=0, both errors 0.
- Write latency: `mem_we`/`mem_addr`/`mem_wdata` are registered and asserted the cycle after acceptance, for exactly one cycle.
- Throughput: one byte per cycle in LOAD. Pad writes are one per cycle.
- RELEASE begins the cycle after the final data write or pad write, so the last write is complete before `core_branch_en`.
- `load_done` rises the cycle after RELEASE.
- `rst` mid-load returns to LOAD with `byte_count`=0. Memory contents are not cleared. Outputs take reset values the cycle after `rst` is sampled.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum (mod 256) covers every accepted byte except the one flagged `in_last`.
  - The `in_last` byte is a checksum: it is not written and does not increment `byte_count`. Padding is based on data bytes only.
  - If sum ≠ checksum byte: `err_checksum`=1 and go to ERROR (no pad, no release). If equal: PAD/RELEASE as normal.
- Not defined: the `in_last` byte is ordinary data. `err_checksum` is tied 0 and no sum logic is present.

## Test plan
- Stream 8 bytes B3,04,5A,01,93,84,14,00 back-to-back, `in_last` on 8th -> writes to addr 0..7 one cycle after each accept. `byte_count`=8. One-cycle `core_branch_en` with pc 0. `core_stall` falls. `load_done`=1.
- Stream 5 bytes with `in_last` on 5th -> 3 pad writes of 00 at addr 5,6,7. `byte_count`=8. Release follows the last pad write.
- Gapped `in_valid` (valid every 3rd cycle) -> writes only for accepted bytes. Addresses contiguous. `core_stall` held at 1 throughout.
- `ADDR_W`=4: stream 17 bytes without `in_last` -> 16 writes. 17th byte not written. `err_overflow`=1. `in_ready`=0. `core_stall` stays 1.
- Assert `rst` after 3 bytes, then stream 4 new bytes -> writes restart at addr 0. Release occurs after the 4th new byte.
- With `LOADER_CHECKSUM_EN`: data 01,02,03,04, last byte 0A -> 4 writes, release. With last byte 0B instead -> `err_checksum`=1, no release, `core_stall`=1.

Source files
------------

// File: rtl/imem_prog_loader.sv
// imem_prog_loader: streams a byte image into the byte-wide instruction
// memory while holding fetch stalled. Once the image is in, it pads to a
// word boundary, redirects fetch to START_PC and releases the core.
// Optional feature: define LOADER_CHECKSUM_EN to treat the in_last byte as
// an 8-bit additive checksum over the data bytes instead of image data.
module imem_prog_loader #(
  parameter int          ADDR_W    = 16,
  parameter int          BASE_ADDR = 0,
  parameter logic [63:0] START_PC  = 64'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_stall,
  output logic              core_branch_en,
  output logic [63:0]       core_branch_pc,
  output logic              load_done,
  output logic [ADDR_W:0]   byte_count,
  output logic              err_overflow,
  output logic              err_checksum
);

  typedef enum logic [2:0] {S_LOAD, S_PAD, S_RELEASE, S_RUN, S_ERROR} state_t;
  state_t state;

  // Two spare bits so BASE_ADDR + byte_count can reach 2^ADDR_W without wrapping.
  localparam int AW = ADDR_W + 2;

  logic [AW-1:0]   wr_full;
  logic            wr_ovf;
  logic            accept;
  logic [ADDR_W:0] cnt_inc;

  assign wr_full  = AW'(BASE_ADDR) + AW'(byte_count);
  assign wr_ovf   = |wr_full[AW-1:ADDR_W];
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = byte_count + 1'b1;

  // The redirect target never changes.
  assign core_branch_pc = START_PC;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
`else
  assign err_checksum = 1'b0;
`endif

  // Loader FSM; every output except branch_pc is a register updated here.
  // A PAD visit with an already aligned count writes nothing: it just gives
  // the final data write a cycle to land before the redirect is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_LOAD;
      in_ready       <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= ADDR_W'(BASE_ADDR);
      mem_wdata      <= 8'h00;
      core_stall     <= 1'b1;
      core_branch_en <= 1'b0;
      load_done      <= 1'b0;
      byte_count     <= '0;
      err_overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_checksum   <= 1'b0;
      csum           <= 8'h00;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            if (in_last) begin
              in_ready <= 1'b0;
              if (csum != in_byte) begin
                err_checksum <= 1'b1;
                state        <= S_ERROR;
              end else begin
                state        <= S_PAD;
              end
            end else
`endif
            if (wr_ovf) begin
              err_overflow <= 1'b1;
              in_ready     <= 1'b0;
              state        <= S_ERROR;
            end else begin
              mem_we     <= 1'b1;
              mem_addr   <= wr_full[ADDR_W-1:0];
              mem_wdata  <= in_byte;
              byte_count <= cnt_inc;
`ifdef LOADER_CHECKSUM_EN
              csum       <= csum + in_byte;
`endif
              if (in_last) begin
                in_ready <= 1'b0;
                state    <= S_PAD;
              end
            end
          end
        end
        S_PAD: begin
          if (byte_count[1:0] == 2'b00) begin
            core_branch_en <= 1'b1;
            state          <= S_RELEASE;
          end else if (wr_ovf) begin
            err_overflow <= 1'b1;
            state        <= S_ERROR;
          end else begin
            mem_we     <= 1'b1;
            mem_addr   <= wr_full[ADDR_W-1:0];
            mem_wdata  <= 8'h00;
            byte_count <= cnt_inc;
          end
        end
        S_RELEASE: begin
          core_branch_en <= 1'b0;
          core_stall     <= 1'b0;
          load_done      <= 1'b1;
          state          <= S_RUN;
        end
        S_RUN:   state <= S_RUN;
        S_ERROR: state <= S_ERROR;
        default: begin
          in_ready <= 1'b0;
          state    <= S_ERROR;
        end
      endcase
    end
  end

endmodule
